data_mem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 43 ++++
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// FSM state encoding, latency floor and word-index width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LATENCY_MIN = 1;

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, synchronous read with a
// clearable output register, and an asynchronous debug read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = idx_width(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents survive reset on purpose: only the read register is cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= 32'd0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else if (rd_clr) begin
            rd_data <= 32'd0;
        end
    end

    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage; stalls the pipeline while busy.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses via resp_err instead of performing them.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic                              req_write,
    input  logic [31:0]                       req_addr,
    input  logic [31:0]                       req_wdata,
    output logic                              req_ready,
    output logic                              stall,
    output logic                              resp_valid,
    output logic [31:0]                       resp_rdata,
    output logic                              resp_err,
    input  logic [idx_width(DEPTH_WORDS)-1:0] dbg_addr,
    output logic [31:0]                       dbg_rdata,
    output logic [1:0]                        dbg_state
);

    localparam int AW = idx_width(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Handshake: a request is accepted on a rising edge where req_valid and
    // req_ready are both high. req_ready is high only in IDLE; req_* are
    // captured at that edge and ignored afterwards. resp_valid is a one-cycle
    // pulse with no back-pressure from the pipeline.

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          access;

    logic          write_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          misaligned;
    logic          unused_bits;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req_valid) begin
                write_q <= req_write;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT;
                    cnt_next   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign stall      = ((state == IDLE) && req_valid) || (state == WAIT);
    assign resp_valid = (state == RESP);
    assign dbg_state  = state;

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned  = (addr_q[1:0] != 2'b00);
    assign unused_bits = ^req_addr[31:AW+2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= misaligned;
        end
    end

    assign resp_err = err_q;
`else
    assign misaligned  = 1'b0;
    assign unused_bits = ^{req_addr[31:AW+2], addr_q[1:0]};
    assign resp_err    = 1'b0;
`endif

    // Stores and flagged accesses return zero data; loads read on the access edge.
    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (access && write_q && !misaligned),
        .wr_addr  (addr_q[AW+1:2]),
        .wr_data  (wdata_q),
        .rd_en    (access && !write_q && !misaligned),
        .rd_clr   (access && (write_q || misaligned)),
        .rd_addr  (addr_q[AW+1:2]),
        .rd_data  (resp_rdata),
        .dbg_addr (dbg_addr),
        .dbg_rdata(dbg_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table, hand-written
// corner sequences and randomized traffic against a word-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic          stall;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_rdata;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    logic [32:0] exp_q [$];

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .stall     (stall),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit is_flagged(input logic [31:0] a);
        return ALIGN_EN && (a % 4 != 0);
    endfunction

    // Reference model: a plain word array indexed by byte address / 4 modulo depth.
    function automatic logic [32:0] model_expect(input logic w, input logic [31:0] a);
        if (is_flagged(a)) return {1'b1, 32'd0};
        if (w) return {1'b0, 32'd0};
        return {1'b0, model_mem[word_of(a)]};
    endfunction

    function automatic void model_apply(input logic w, input logic [31:0] a, input logic [31:0] d);
        if (w && !is_flagged(a)) model_mem[word_of(a)] = d;
    endfunction

    // Driver: one full request, checking handshake timing along the way.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
        int guard;
        int lat;
        int stalls;
        rd = 32'd0;
        er = 1'b0;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            #1;
            guard++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        stalls = int'(stall);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            stalls += int'(stall);
            @(posedge clock);
            #1;
            lat++;
        end
        check("resp_seen", 32'(resp_valid), 32'd1);
        check("latency", 32'(lat), 32'(LAT + 1));
        check("stall_cycles", 32'(stalls), 32'(LAT + 1));
        check("resp_stall_low", 32'(stall), 32'd0);
        check("resp_ready_low", 32'(req_ready), 32'd0);
        rd = resp_rdata;
        er = resp_err;
        @(posedge clock);
        #1;
        check("idle_after_resp", 32'(req_ready), 32'd1);
    endtask

    // Scoreboard transaction: expectation queued from the model, then compared.
    task automatic txn(input string name, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        er;
        logic [32:0] exp;
        exp_q.push_back(model_expect(w, a));
        do_req(w, a, d, rd, er);
        exp = exp_q.pop_front();
        check({name, "_rdata"}, rd, exp[31:0]);
        check({name, "_err"}, 32'(er), 32'(exp[32]));
        model_apply(w, a, d);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] old_val;
        logic        w;
        int          n;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        dbg_addr  = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;

        vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h400, 32'h12345678, 32'h0,        1'b0};
        vecs[3] = '{1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0};
        vecs[4] = '{1'b0, 32'h13,  32'h0,        ALIGN_EN ? 32'h0 : 32'hDEADBEEF, ALIGN_EN};
        vecs[5] = '{1'b1, 32'h3FC, 32'hAAAA5555, 32'h0,        1'b0};
        vecs[6] = '{1'b0, 32'h7FC, 32'h0,        32'hAAAA5555, 1'b0};
        vecs[7] = '{1'b1, 32'h14,  32'h0F0F0F0F, 32'h0,        1'b0};
        vecs[8] = '{1'b0, 32'h814, 32'h0,        32'h0F0F0F0F, 1'b0};
        vecs[9] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].w, vecs[i].addr, vecs[i].wdata, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            model_apply(vecs[i].w, vecs[i].addr, vecs[i].wdata);
        end
        dbg_addr = AW'(4);
        #1;
        check("dbg_word4", dbg_rdata, 32'hDEADBEEF);
        dbg_addr = AW'(0);
        #1;
        check("dbg_word0", dbg_rdata, 32'h12345678);

        // Back-to-back: second load held across RESP, accepted in the following IDLE.
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        @(posedge clock);
        #1;
        req_addr = 32'h400;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("b2b_first_resp", 32'(resp_valid), 32'd1);
        check("b2b_first_rdata", resp_rdata, model_mem[4]);
        check("b2b_resp_stall", 32'(stall), 32'd0);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) begin
                check("b2b_idle_stall", 32'(stall), 32'd1);
                check("b2b_idle_ready", 32'(req_ready), 32'd1);
            end
            if (n == 2) req_valid = 1'b0;
        end while (!resp_valid && n < 50);
        check("b2b_spacing", 32'(n), 32'(LAT + 2));
        check("b2b_second_rdata", resp_rdata, model_mem[0]);
        @(posedge clock);
        #1;

        // Reset during an in-flight store drops the store.
        old_val = 32'hCAFEF00D;
        txn("pre_store", 1'b1, 32'h20, old_val);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h11111111;
        @(posedge clock);
        #1;
        check("mid_in_wait", 32'(dbg_state), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_stall_req", 32'(stall), 32'd1);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        req_valid = 1'b0;
        #1;
        check("mid_rst_stall_idle", 32'(stall), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        dbg_addr = AW'(8);
        #1;
        check("mid_rst_dbg", dbg_rdata, old_val);
        txn("mid_rst_load", 1'b0, 32'h20, 32'd0);

        // Randomized traffic on 16 words with address aliasing.
        for (int i = 0; i < 16; i++) begin
            txn("rnd_init", 1'b1, 32'(i * 4), $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) * DEPTH * 4);
            d = $urandom;
            txn("rnd", w, a, d);
        end
        for (int i = 0; i < 16; i += 5) begin
            dbg_addr = AW'(i);
            #1;
            check("rnd_dbg", dbg_rdata, model_mem[i]);
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
